updown_counter: RTL

UPDOWN_COUNTER -- requirements
Module: updown_counter

---
 rtl/counter_pkg.sv | 9 +
 rtl/updown_counter_if.sv | 19 +
 rtl/updown_counter.sv | 77 +++++++
 3 files changed

// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared mode and default-size constants for counter blocks
package counter_pkg;

  localparam int MODE_WRAP  = 0;
  localparam int MODE_SAT   = 1;
  localparam int DEF_WIDTH  = 4;
  localparam int DEF_MODULO = 16;

endpackage

// File: rtl/updown_counter_if.sv
// rtl/updown_counter_if.sv - command/status bundle for updown_counter
interface updown_counter_if
  import counter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) ();

  logic             en;
  logic             up;
  logic             ld;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             ovf;

  modport master (output en, up, ld, d, input q, tc, ovf);
  modport slave  (input en, up, ld, d, output q, tc, ovf);

endinterface

// File: rtl/updown_counter.sv
// rtl/updown_counter.sv - modulo up/down counter with load, wrap or saturate at bounds
module updown_counter
  import counter_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int MODULO   = DEF_MODULO,
  parameter int SATURATE = MODE_WRAP
) (
  input  logic             ck,
  input  logic             res,
  input  logic             en,
  input  logic             up,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf
);

  if (MODULO < 2 || MODULO > (2 ** WIDTH)) begin : g_bad_modulo
    $error("updown_counter: MODULO must lie in 2..2**WIDTH");
  end

  // One extra bit so MODULO == 2**WIDTH stays representable.
  localparam logic [WIDTH:0] MOD_EXT = (WIDTH + 1)'(MODULO);
  localparam logic [WIDTH:0] MAX_EXT = (WIDTH + 1)'(MODULO - 1);

  logic [WIDTH:0]   q_ext;
  logic [WIDTH:0]   d_ext;
  logic [WIDTH:0]   inc_ext;
  logic [WIDTH:0]   dec_ext;
  logic [WIDTH-1:0] q_next;
  logic             ovf_next;

  assign q_ext   = {1'b0, q};
  assign d_ext   = {1'b0, d};
  assign inc_ext = q_ext + 1'b1;
  assign dec_ext = q_ext - 1'b1;

  always_comb begin
    q_next   = q;
    ovf_next = 1'b0;
    if (ld) begin
      q_next = (d_ext < MOD_EXT) ? d : MAX_EXT[WIDTH-1:0];
    end else if (en) begin
      if (up) begin
        if (inc_ext == MOD_EXT) begin
          ovf_next = 1'b1;
          q_next   = (SATURATE == MODE_SAT) ? q : '0;
        end else begin
          q_next = inc_ext[WIDTH-1:0];
        end
      end else begin
        // A borrow out of the top bit means q was already 0.
        if (dec_ext[WIDTH]) begin
          ovf_next = 1'b1;
          q_next   = (SATURATE == MODE_SAT) ? q : MAX_EXT[WIDTH-1:0];
        end else begin
          q_next = dec_ext[WIDTH-1:0];
        end
      end
    end
  end

  always_ff @(posedge ck or negedge res) begin
    if (!res) begin
      q   <= '0;
      ovf <= 1'b0;
    end else begin
      q   <= q_next;
      ovf <= ovf_next;
    end
  end

  assign tc = up ? (q_ext == MAX_EXT) : (q == '0);

endmodule
